// File: rtl/simon_uart_host_link.sv
// Host-side endpoint of the Simon cipher UART link: sends a 13-byte 8N1 request
// {mode, key, plaintext} and assembles the 4-byte response into a 32-bit word.
module simon_uart_host_link #(
   parameter int CLKS_PER_BIT = 868,
   parameter int RESP_TIMEOUT = 2_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mode,
   input  logic [63:0] key,
   input  logic [31:0] plntxt,
   input  logic        rxd_in,
   output logic        txd_out,
   output logic        busy,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        timeout_err,
   output logic        frame_err
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(RESP_TIMEOUT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(RESP_TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_ONE   = TW'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TX_BIT    = 3'd1,
      S_WAIT_RESP = 3'd2,
      S_RX_BIT    = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t         r_state;
   logic [103:0]   r_frame;
   logic [CW-1:0]  r_clk_cnt;
   logic [3:0]     r_bit_idx;
   logic [3:0]     r_byte_cnt;
   logic [TW-1:0]  r_tmo_cnt;
   logic           r_rx_s1;
   logic           r_rx_s2;
   logic           r_rx_prev;
   logic [7:0]     r_rx_byte;
   logic [31:0]    r_resp;
   logic           r_txd;
   logic           r_busy;
   logic [31:0]    r_result;
   logic           r_valid;
   logic           r_tmo_err;
   logic           r_frm_err;

   logic           w_rx_fall;
   logic           w_bit_end;
   logic [7:0]     w_tx_byte;

   assign w_rx_fall = r_rx_prev & ~r_rx_s2;
   assign w_bit_end = (r_clk_cnt == BIT_LAST);
   assign w_tx_byte = r_frame[103:96];

   assign txd_out      = r_txd;
   assign busy         = r_busy;
   assign result       = r_result;
   assign result_valid = r_valid;
   assign timeout_err  = r_tmo_err;
   assign frame_err    = r_frm_err;

   // Two-flop synchronizer for rxd_in plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_s1   <= rxd_in;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
      end
   end

   // Transaction FSM: serializer, response deserializer, timeout and status pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_frame    <= 104'd0;
         r_clk_cnt  <= '0;
         r_bit_idx  <= 4'd0;
         r_byte_cnt <= 4'd0;
         r_tmo_cnt  <= '0;
         r_rx_byte  <= 8'd0;
         r_resp     <= 32'd0;
         r_txd      <= 1'b1;
         r_busy     <= 1'b0;
         r_result   <= 32'd0;
         r_valid    <= 1'b0;
         r_tmo_err  <= 1'b0;
         r_frm_err  <= 1'b0;
      end else begin
         r_valid   <= 1'b0;
         r_tmo_err <= 1'b0;
         r_frm_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_txd <= 1'b1;
               if (start) begin
                  r_frame    <= {7'd0, mode, key, plntxt};
                  r_txd      <= 1'b0;
                  r_busy     <= 1'b1;
                  r_clk_cnt  <= '0;
                  r_bit_idx  <= 4'd0;
                  r_byte_cnt <= 4'd0;
                  r_state    <= S_TX_BIT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_TX_BIT: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (r_bit_idx == 4'd9) begin
                     r_bit_idx <= 4'd0;
                     if (r_byte_cnt == 4'd12) begin
                        r_byte_cnt <= 4'd0;
                        r_tmo_cnt  <= '0;
                        r_txd      <= 1'b1;
                        r_state    <= S_WAIT_RESP;
                     end else begin
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                        r_frame    <= {r_frame[95:0], 8'd0};
                        r_txd      <= 1'b0;
                     end
                  end else begin
                     // Index 0..7 completing means data bit of the same index goes out next
                     r_bit_idx <= r_bit_idx + 4'd1;
                     r_txd     <= (r_bit_idx == 4'd8) ? 1'b1 : w_tx_byte[r_bit_idx[2:0]];
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_ONE;
               end
            end
            S_WAIT_RESP: begin
               if (w_rx_fall) begin
                  r_clk_cnt <= '0;
                  r_bit_idx <= 4'd0;
                  r_tmo_cnt <= '0;
                  r_state   <= S_RX_BIT;
               end else if (r_tmo_cnt == TMO_LAST) begin
                  r_tmo_err <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
               end
            end
            S_RX_BIT: begin
               if (r_bit_idx == 4'd0) begin
                  if (r_clk_cnt == HALF_LAST) begin
                     r_clk_cnt <= '0;
                     if (r_rx_s2) begin
                        r_state <= S_WAIT_RESP;
                     end else begin
                        r_bit_idx <= 4'd1;
                     end
                  end else begin
                     r_clk_cnt <= r_clk_cnt + CNT_ONE;
                  end
               end else if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (r_bit_idx == 4'd9) begin
                     r_bit_idx <= 4'd0;
                     if (!r_rx_s2) begin
                        r_frm_err <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                     end else if (r_byte_cnt == 4'd3) begin
                        r_resp  <= {r_resp[23:0], r_rx_byte};
                        r_state <= S_DONE;
                     end else begin
                        r_resp     <= {r_resp[23:0], r_rx_byte};
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                        r_state    <= S_WAIT_RESP;
                     end
                  end else begin
                     r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
                     r_bit_idx <= r_bit_idx + 4'd1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_ONE;
               end
            end
            S_DONE: begin
               r_result <= r_resp;
               r_valid  <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_txd   <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_simon_uart_host_link.sv
// Randomized bench for simon_uart_host_link with a Simon32/64 loopback responder
// and a line-level decoder of the request frame.
module tb_simon_uart_host_link;
   localparam int CPB = 4;
   localparam int TMO = 400;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [63:0] key = 64'd0;
   logic [31:0] plntxt = 32'd0;
   logic        rxd_in = 1'b1;
   logic        txd_out;
   logic        busy;
   logic [31:0] result;
   logic        result_valid;
   logic        timeout_err;
   logic        frame_err;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [7:0] tx_bytes [$];
   int         tx_stop_bad = 0;
   logic       mon_busy = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_byte = 8'd0;

   int          n_valid = 0, n_tmo = 0, n_ferr = 0, n_wide = 0;
   logic [31:0] v_result = 32'd0;
   logic        v_busy = 1'b0, t_busy = 1'b0, f_busy = 1'b0;
   int          t_cyc = 0;
   logic        p_valid = 1'b0, p_tmo = 1'b0, p_ferr = 1'b0;
   logic [31:0] exp_result = 32'd0;

   simon_uart_host_link #(.CLKS_PER_BIT(CPB), .RESP_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key), .plntxt(plntxt),
      .rxd_in(rxd_in), .txd_out(txd_out), .busy(busy), .result(result),
      .result_valid(result_valid), .timeout_err(timeout_err), .frame_err(frame_err)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check_eq(input string tag, input logic [103:0] got, input logic [103:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // ---------------- Simon32/64 reference ----------------
   function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
      return (v << s) | (v >> (16 - s));
   endfunction

   function automatic logic [15:0] simon_f(input logic [15:0] x);
      return (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2);
   endfunction

   function automatic logic [511:0] simon_keys(input logic [63:0] k);
      logic [15:0] ks [0:31];
      logic [15:0] t;
      logic [30:0] z;
      logic [511:0] all;
      z = 31'b1111101000100101011000011100110;
      ks[0] = k[15:0]; ks[1] = k[31:16]; ks[2] = k[47:32]; ks[3] = k[63:48];
      for (int i = 0; i < 28; i++) begin
         t = rol16(ks[i+3], 13) ^ ks[i+1];
         t = t ^ rol16(t, 15);
         ks[i+4] = ~ks[i] ^ t ^ {15'd0, z[30 - (i % 31)]} ^ 16'd3;
      end
      for (int i = 0; i < 32; i++) all[16*i +: 16] = ks[i];
      return all;
   endfunction

   function automatic logic [31:0] simon_enc(input logic [63:0] k, input logic [31:0] p);
      logic [511:0] ks;
      logic [15:0] x, y, t;
      ks = simon_keys(k);
      x = p[31:16]; y = p[15:0];
      for (int r = 0; r < 32; r++) begin
         t = x;
         x = y ^ simon_f(x) ^ ks[16*r +: 16];
         y = t;
      end
      return {x, y};
   endfunction

   function automatic logic [31:0] simon_dec(input logic [63:0] k, input logic [31:0] c);
      logic [511:0] ks;
      logic [15:0] x, y, t;
      ks = simon_keys(k);
      x = c[31:16]; y = c[15:0];
      for (int r = 31; r >= 0; r--) begin
         t = y;
         y = x ^ simon_f(y) ^ ks[16*r +: 16];
         x = t;
      end
      return {x, y};
   endfunction

   // ---------------- line decoder for txd_out ----------------
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         mon_busy = 1'b0;
      end else if (!mon_busy) begin
         if (txd_out == 1'b0) begin
            mon_busy = 1'b1;
            mon_cnt  = 0;
         end
      end else begin
         mon_cnt++;
         if (((mon_cnt - 1) % CPB) == 0) begin
            int k;
            k = (mon_cnt - 1) / CPB;
            if (k == 0) begin
               if (txd_out) mon_busy = 1'b0;
            end else if (k <= 8) begin
               mon_byte[k-1] = txd_out;
            end else begin
               if (txd_out) tx_bytes.push_back(mon_byte);
               else tx_stop_bad++;
               mon_busy = 1'b0;
            end
         end
      end
   end

   // ---------------- status pulse recorder ----------------
   initial forever begin
      @(negedge clk);
      if (result_valid) begin
         n_valid++; v_result = result; v_busy = busy;
         if (p_valid) n_wide++;
      end
      if (timeout_err) begin
         n_tmo++; t_cyc = cyc; t_busy = busy;
         if (p_tmo) n_wide++;
      end
      if (frame_err) begin
         n_ferr++; f_busy = busy;
         if (p_ferr) n_wide++;
      end
      p_valid = result_valid; p_tmo = timeout_err; p_ferr = frame_err;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rxd_in = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd_in = b[i];
         tick(CPB);
      end
      rxd_in = stop_bit;
      tick(CPB);
      rxd_in = 1'b1;
   endtask

   function automatic int pulse_cnt(input int which);
      case (which)
         0: return n_valid;
         1: return n_tmo;
         default: return n_ferr;
      endcase
   endfunction

   task automatic wait_pulse(input int which, input int base, input int limit);
      int b;
      b = 0;
      while (pulse_cnt(which) == base && b < limit) begin
         tick(1);
         b++;
      end
   endtask

   // kind: 0 normal, 1 no responder, 2 bad stop on 2nd byte, 3 glitch first, 4 start during TX
   task automatic run_txn(input logic m, input logic [63:0] k, input logic [31:0] p, input int kind);
      logic [103:0] exp_frame, got_frame;
      logic [31:0]  resp, exp;
      int nv0, nt0, nf0, t0, b;
      exp_frame = {7'd0, m, k, p};
      exp = m ? simon_dec(k, p) : simon_enc(k, p);
      tx_bytes.delete();
      nv0 = n_valid; nt0 = n_tmo; nf0 = n_ferr;
      tick(1);
      check_eq("idle_busy", 104'(busy), 104'(0));
      mode = m; key = k; plntxt = p; start = 1'b1;
      tick(1);
      start = 1'b0;
      t0 = cyc;
      check_eq("tx_start_bit", 104'(txd_out), 104'(0));
      check_eq("busy_rise", 104'(busy), 104'(1));
      mode = 1'($urandom); key = {$urandom, $urandom}; plntxt = $urandom;
      if (kind == 4) begin
         tick(100);
         start = 1'b1;
         tick(1);
         start = 1'b0;
      end
      b = 0;
      while (tx_bytes.size() < 13 && b < 700) begin
         tick(1);
         b++;
      end
      check_eq("tx_byte_count", 104'(tx_bytes.size()), 104'(13));
      got_frame = 104'd0;
      for (int i = 0; i < 13; i++)
         got_frame = {got_frame[95:0], (i < tx_bytes.size()) ? tx_bytes[i] : 8'h00};
      check_eq("tx_frame", got_frame, exp_frame);
      resp = got_frame[96] ? simon_dec(got_frame[95:32], got_frame[31:0])
                           : simon_enc(got_frame[95:32], got_frame[31:0]);
      tick(6);
      if (kind == 1) begin
         wait_pulse(1, nt0, 1000);
         check_eq("tmo_pulse", 104'(n_tmo - nt0), 104'(1));
         check_eq("tmo_latency", 104'(t_cyc - t0), 104'(130 * CPB + TMO));
         check_eq("tmo_busy_drop", 104'(t_busy), 104'(0));
         check_eq("tmo_no_valid", 104'(n_valid - nv0), 104'(0));
         check_eq("tmo_result_held", 104'(result), 104'(exp_result));
      end else if (kind == 2) begin
         send_byte(resp[31:24], 1'b1);
         tick($urandom_range(0, 20));
         send_byte(resp[23:16], 1'b0);
         wait_pulse(2, nf0, 200);
         check_eq("ferr_pulse", 104'(n_ferr - nf0), 104'(1));
         check_eq("ferr_busy_drop", 104'(f_busy), 104'(0));
         check_eq("ferr_no_valid", 104'(n_valid - nv0), 104'(0));
         tick(5);
         check_eq("ferr_result_held", 104'(result), 104'(exp_result));
         check_eq("ferr_idle", 104'(busy), 104'(0));
      end else begin
         if (kind == 3) begin
            rxd_in = 1'b0;
            tick(1);
            rxd_in = 1'b1;
            tick(10);
         end
         for (int i = 3; i >= 0; i--) begin
            send_byte(resp[8*i +: 8], 1'b1);
            tick($urandom_range(0, 30));
         end
         wait_pulse(0, nv0, 200);
         check_eq("valid_count", 104'(n_valid - nv0), 104'(1));
         check_eq("valid_result", 104'(v_result), 104'(exp));
         check_eq("valid_busy_drop", 104'(v_busy), 104'(0));
         check_eq("no_err_pulse", 104'((n_tmo - nt0) + (n_ferr - nf0)), 104'(0));
         exp_result = exp;
      end
      tick(60);
      check_eq("no_extra_frame", 104'(tx_bytes.size()), 104'(13));
      check_eq("result_hold", 104'(result), 104'(exp_result));
   endtask

   initial begin
      int nv0, nt0, nf0, b;
      tick(3);
      check_eq("rst_txd", 104'(txd_out), 104'(1));
      check_eq("rst_busy", 104'(busy), 104'(0));
      check_eq("rst_result", 104'(result), 104'(0));
      check_eq("rst_pulses", 104'({result_valid, timeout_err, frame_err}), 104'(0));
      rst = 1'b1;
      tick(3);

      run_txn(1'b0, 64'h1918111009080100, 32'h65656877, 0);
      check_eq("enc_vector", 104'(result), 104'(32'hc69be9bb));
      run_txn(1'b1, 64'h1918111009080100, 32'hc69be9bb, 0);
      check_eq("dec_vector", 104'(result), 104'(32'h65656877));

      run_txn(1'($urandom), {$urandom, $urandom}, $urandom, 1);
      run_txn(1'($urandom), {$urandom, $urandom}, $urandom, 2);
      run_txn(1'($urandom), {$urandom, $urandom}, $urandom, 0);
      run_txn(1'($urandom), {$urandom, $urandom}, $urandom, 4);
      run_txn(1'($urandom), {$urandom, $urandom}, $urandom, 3);

      // Async reset in the middle of the request frame
      tx_bytes.delete();
      nv0 = n_valid; nt0 = n_tmo; nf0 = n_ferr;
      mode = 1'($urandom); key = {$urandom, $urandom}; plntxt = $urandom;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      b = 0;
      while (tx_bytes.size() < 6 && b < 400) begin
         tick(1);
         b++;
      end
      check_eq("rst_reach_byte6", 104'(tx_bytes.size()), 104'(6));
      tick(3);
      check_eq("pre_rst_txd", 104'(txd_out), 104'(0));
      #2 rst = 1'b0;
      #1;
      check_eq("async_rst_txd", 104'(txd_out), 104'(1));
      check_eq("async_rst_busy", 104'(busy), 104'(0));
      tick(5);
      check_eq("async_rst_no_pulse", 104'((n_valid - nv0) + (n_tmo - nt0) + (n_ferr - nf0)), 104'(0));
      check_eq("async_rst_result", 104'(result), 104'(0));
      exp_result = 32'd0;
      rst = 1'b1;
      tick(3);
      run_txn(1'($urandom), {$urandom, $urandom}, $urandom, 0);

      for (int i = 0; i < 6; i++)
         run_txn(1'($urandom), {$urandom, $urandom}, $urandom, int'($urandom_range(0, 4)));

      check_eq("pulse_width", 104'(n_wide), 104'(0));
      check_eq("tx_stop_bits", 104'(tx_stop_bad), 104'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
